// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter in front of the 8-bit byte SRAM slave.
// Grants are held for a whole cyc envelope; a watchdog ends stalled strobes with a one-cycle err.
module wb_arbiter2 #(
  parameter int unsigned ADDR_WIDTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // master 0: host/SPI bridge
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [7:0]            m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  output logic [7:0]            m0_dat_o,
  // master 1: Levenshtein engine
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [7:0]            m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [7:0]            m1_dat_o,
  // shared slave
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [7:0]            s_dat_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  input  logic [7:0]            s_dat_i,
  output logic [1:0]            gnt_o
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_M0   = 2'b01,
    GNT_M1   = 2'b10
  } gnt_e;

  localparam bit          WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  gnt_e             gnt_q, gnt_d;
  logic             last_q, last_d;   // 1 = master 1 was granted most recently
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  logic sel_cyc;
  logic sel_stb;
  logic slave_resp;
  logic timeout;
  logic wd_err;

  assign sel_cyc = ((gnt_q == GNT_M0) & m0_cyc_i) | ((gnt_q == GNT_M1) & m1_cyc_i);
  assign sel_stb = ((gnt_q == GNT_M0) & m0_stb_i) | ((gnt_q == GNT_M1) & m1_stb_i);

  assign slave_resp = s_ack_i | s_err_i | s_rty_i;
  assign timeout    = WD_EN && (wd_cnt_q == CNT_MAX);
  // A genuine slave response in the timeout cycle takes precedence over the forced err.
  assign wd_err     = timeout & ~s_ack_i & ~s_rty_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      gnt_q    <= GNT_NONE;
      last_q   <= 1'b1;
      wd_cnt_q <= '0;
    end else begin
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // Next-state: hold while the owner keeps cyc, otherwise re-arbitrate in the same edge
  always_comb begin
    gnt_d  = gnt_q;
    last_d = last_q;
    if (!sel_cyc) begin
      case ({m1_cyc_i, m0_cyc_i})
        2'b11:   gnt_d = last_q ? GNT_M0 : GNT_M1;
        2'b01:   gnt_d = GNT_M0;
        2'b10:   gnt_d = GNT_M1;
        default: gnt_d = GNT_NONE;
      endcase
      if (gnt_d != GNT_NONE) begin
        last_d = (gnt_d == GNT_M1);
      end
    end
  end

  // Watchdog next count: saturating, cleared by response, grant change, idle strobe or timeout
  always_comb begin
    wd_cnt_d = '0;
    if (WD_EN && (gnt_d == gnt_q) && sel_cyc && sel_stb && !slave_resp && !timeout) begin
      wd_cnt_d = (wd_cnt_q == CNT_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
    end
  end

  // Output mux
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    case (gnt_q)
      GNT_M0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~timeout;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | wd_err;
        m0_rty_o = s_rty_i;
      end
      GNT_M1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~timeout;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | wd_err;
        m1_rty_o = s_rty_i;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = gnt_q;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with a small SRAM slave model and a read-data scoreboard.
module tb_wb_arbiter2;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       m0_cyc, m0_stb, m0_we;
  logic [1:0] m0_adr;
  logic [7:0] m0_dat;
  logic       m0_ack_o, m0_err_o, m0_rty_o;
  logic [7:0] m0_dat_o;
  logic       m1_cyc, m1_stb, m1_we;
  logic [1:0] m1_adr;
  logic [7:0] m1_dat;
  logic       m1_ack_o, m1_err_o, m1_rty_o;
  logic [7:0] m1_dat_o;
  logic       s_cyc_o, s_stb_o, s_we_o;
  logic [1:0] s_adr_o;
  logic [7:0] s_dat_o;
  logic       s_ack_i, s_err_i, s_rty_i;
  logic [7:0] s_dat_i;
  logic [1:0] gnt_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  ref_mem [0:3];

  // slave model: registered one-cycle ack, dropped on back-to-back strobes
  logic [7:0] mem [0:3];
  logic       ack_q     = 1'b0;
  logic [7:0] rdat_q    = 8'h00;
  logic       slave_en  = 1'b1;
  logic       force_ack = 1'b0;

  assign s_ack_i = ack_q | force_ack;
  assign s_err_i = 1'b0;
  assign s_rty_i = 1'b0;
  assign s_dat_i = rdat_q;

  always @(posedge clk) begin
    if (s_cyc_o && s_stb_o && !ack_q && slave_en) begin
      ack_q  <= 1'b1;
      rdat_q <= mem[s_adr_o];
      if (s_we_o) mem[s_adr_o] <= s_dat_o;
    end else begin
      ack_q <= 1'b0;
    end
  end

  always #5 clk = ~clk;

  wb_arbiter2 #(.ADDR_WIDTH(2), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
    .gnt_o(gnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input logic we, input logic [1:0] adr, input logic [7:0] dat);
    if (m == 0) begin
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = we; m0_adr = adr; m0_dat = dat;
    end else begin
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = we; m1_adr = adr; m1_dat = dat;
    end
    if (!we) exp_q.push_back(ref_mem[adr]);
  endtask

  task automatic wait_ack(input int m);
    bit         got = 1'b0;
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat;
    logic [7:0] e;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((m == 0 ? m0_ack_o : m1_ack_o) === 1'b1) begin
        got = 1'b1;
        break;
      end
      chk("idle_ack_other", (m == 0 ? m1_ack_o : m0_ack_o), 0);
    end
    if (!got) begin
      checks++;
      errors++;
      $error("FAIL ack_wait master %0d observed no ack expected ack within 20 cycles", m);
    end else begin
      chk("ack_other_zero", (m == 0 ? m1_ack_o : m0_ack_o), 0);
      chk("err_at_ack", (m == 0 ? m0_err_o : m1_err_o), 0);
      we  = (m == 0) ? m0_we  : m1_we;
      adr = (m == 0) ? m0_adr : m1_adr;
      dat = (m == 0) ? m0_dat : m1_dat;
      if (we) begin
        ref_mem[adr] = dat;
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow observed read ack expected queued entry");
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", (m == 0 ? m0_dat_o : m1_dat_o), e);
      end
    end
    if (m == 0) m0_stb = 1'b0; else m1_stb = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed no finish expected finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'h00;
    rst_ni = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_dat = '0;
    m1_cyc = 1'b1; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_dat = '0;

    // 1: reset with both requesting
    tick(); tick();
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_m0_ack", m0_ack_o, 0);
    chk("rst_m1_ack", m1_ack_o, 0);
    chk("rst_m0_err", m0_err_o, 0);
    rst_ni = 1'b1;
    tick();
    chk("rst_release_gnt", gnt_o, 2'b01);
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();
    chk("idle_gnt", gnt_o, 2'b00);

    // 2: single master write then read
    drive(1, 1'b1, 2'd2, 8'hA5);
    chk("lat_gnt_same_cycle", gnt_o, 2'b00);
    chk("lat_s_cyc_same_cycle", s_cyc_o, 0);
    tick();
    chk("m1_gnt", gnt_o, 2'b10);
    chk("m1_s_cyc", s_cyc_o, 1);
    chk("m1_s_stb", s_stb_o, 1);
    chk("m1_s_we", s_we_o, 1);
    chk("m1_s_adr", s_adr_o, 2'd2);
    chk("m1_s_dat", s_dat_o, 8'hA5);
    wait_ack(1);
    drive(1, 1'b0, 2'd2, 8'h00);
    wait_ack(1);
    m1_cyc = 1'b0;
    tick();
    chk("m1_release_gnt", gnt_o, 2'b00);

    // 3: contention and zero-bubble handover
    drive(0, 1'b1, 2'd0, 8'h11);
    drive(1, 1'b1, 2'd1, 8'h22);
    tick();
    chk("cont_gnt_m0", gnt_o, 2'b01);
    wait_ack(0);
    m0_cyc = 1'b0;
    tick();
    chk("handover_gnt_m1", gnt_o, 2'b10);
    chk("handover_s_cyc", s_cyc_o, 1);
    wait_ack(1);
    m1_cyc = 1'b0;
    tick();
    chk("cont_idle", gnt_o, 2'b00);
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    chk("rr_after_m1", gnt_o, 2'b01);
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();
    chk("rr_idle", gnt_o, 2'b00);
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    chk("rr_after_m0", gnt_o, 2'b10);
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();
    chk("rr_idle2", gnt_o, 2'b00);

    // 4: no preemption across three m0 transfers
    drive(0, 1'b1, 2'd3, 8'h33);
    drive(1, 1'b1, 2'd2, 8'h5A);
    tick();
    chk("np_gnt0", gnt_o, 2'b01);
    wait_ack(0);
    chk("np_gnt1", gnt_o, 2'b01);
    drive(0, 1'b0, 2'd3, 8'h00);
    wait_ack(0);
    chk("np_gnt2", gnt_o, 2'b01);
    drive(0, 1'b0, 2'd0, 8'h00);
    wait_ack(0);
    chk("np_gnt3", gnt_o, 2'b01);
    m0_cyc = 1'b0;
    tick();
    chk("np_handover", gnt_o, 2'b10);
    wait_ack(1);
    drive(1, 1'b0, 2'd2, 8'h00);
    wait_ack(1);
    m1_cyc = 1'b0;
    tick();
    chk("np_idle", gnt_o, 2'b00);

    // 5: watchdog timeout, then ack arriving on the timeout cycle
    slave_en = 1'b0;
    drive(0, 1'b1, 2'd1, 8'h66);
    tick();
    chk("wd_gnt", gnt_o, 2'b01);
    chk("wd_err_start", m0_err_o, 0);
    tick(); tick(); tick();
    chk("wd_err_pre", m0_err_o, 0);
    chk("wd_stb_pre", s_stb_o, 1);
    tick();
    chk("wd_err_pulse", m0_err_o, 1);
    chk("wd_stb_forced", s_stb_o, 0);
    chk("wd_gnt_kept", gnt_o, 2'b01);
    chk("wd_m1_err", m1_err_o, 0);
    chk("wd_m0_ack", m0_ack_o, 0);
    tick();
    chk("wd_err_drop", m0_err_o, 0);
    chk("wd_stb_back", s_stb_o, 1);
    tick(); tick(); tick(); tick();
    chk("wd2_stb_forced", s_stb_o, 0);
    force_ack = 1'b1;
    #1;
    chk("wd2_ack_wins", m0_ack_o, 1);
    chk("wd2_no_err", m0_err_o, 0);
    force_ack = 1'b0;
    tick();
    chk("wd2_after_err", m0_err_o, 0);
    chk("wd2_after_stb", s_stb_o, 1);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    slave_en = 1'b1;
    tick();
    chk("wd_idle", gnt_o, 2'b00);

    // 6: reset during an m1 transfer
    drive(1, 1'b1, 2'd0, 8'h77);
    tick();
    chk("mr_gnt", gnt_o, 2'b10);
    chk("mr_stb", s_stb_o, 1);
    rst_ni = 1'b0;
    tick();
    chk("mr_gnt_drop", gnt_o, 2'b00);
    chk("mr_s_cyc", s_cyc_o, 0);
    chk("mr_s_stb", s_stb_o, 0);
    chk("mr_m1_ack", m1_ack_o, 0);
    chk("mr_m0_ack", m0_ack_o, 0);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    chk("mr_idle", gnt_o, 2'b00);

    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
